uart_alu_ctrl: RTL

//  Byte-level controller between UART rx/tx cores and the combinational ALU inside top_interface.

---
 rtl/uart_alu_ctrl_pkg.sv | 38 +++
 rtl/ctrl_timeout_cnt.sv | 41 ++++
 rtl/uart_alu_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_alu_ctrl_pkg.sv
// Package: uart_alu_ctrl_pkg
// Shared definitions for the UART/ALU byte controller. The external ALU uses
// the same opcode values.
//  - opcode localparams for the eight supported ALU operations
//  - 3-bit FSM state encoding
//  - default error byte sent back for an unsupported opcode
//  - op_supported(): true for opcodes the ALU implements
package uart_alu_ctrl_pkg;

  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;

  localparam logic [7:0] ERR_CODE_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_CALC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Module: ctrl_timeout_cnt
// Inter-byte idle counter for uart_alu_ctrl. Only instantiated when
// UART_CTRL_TIMEOUT_EN is defined.
// Ports:
//  clock     in   system clock, rising edge
//  reset     in   synchronous active-low reset
//  clear     in   restart the count at zero (byte accepted or not waiting)
//  count_en  in   advance the count this cycle
//  expire    out  count has reached TIMEOUT_CYCLES-1 while counting
module ctrl_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          at_limit;

  assign at_limit = (count == LIMIT);

  // Saturate at the limit; the owner clears us on the following cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !at_limit) begin
      count <= count + 1'b1;
    end
  end

  assign expire = count_en && at_limit;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Module: uart_alu_ctrl
// Byte-level controller between UART rx/tx cores and a combinational ALU.
// Collects operand A, operand B and an opcode from the receiver, presents them
// to the ALU, registers the result (or ERR_CODE for an unsupported opcode) and
// hands it to the transmitter with a tx_start/tx_done handshake. One frame is
// in flight at a time; bytes arriving while busy are dropped.
//
// Optional feature: define UART_CTRL_TIMEOUT_EN to abort a partially received
// frame after TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP.
//
// Ports:
//  clock       in   system clock, rising edge
//  reset       in   synchronous active-low reset
//  rx_done     in   1-cycle pulse, rx_data valid
//  rx_data     in   received byte
//  tx_done     in   1-cycle pulse, transmitter finished
//  alu_result  in   combinational ALU output
//  alu_a       out  registered operand A
//  alu_b       out  registered operand B
//  alu_op      out  registered opcode (rx_data[5:0])
//  tx_start    out  1-cycle pulse, start transmitting tx_data
//  tx_data     out  byte to transmit, stable until tx_done
//  busy        out  high in CALC, SEND, WAIT_TX
//  op_err      out  1-cycle pulse in CALC for an unsupported opcode
//  timeout     out  1-cycle pulse when a frame is aborted (0 without macro)
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int                N_BITS         = 8,
  parameter logic [N_BITS-1:0] ERR_CODE       = N_BITS'(ERR_CODE_DEFAULT),
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [N_BITS-1:0] rx_data,
  input  logic              tx_done,
  input  logic [N_BITS-1:0] alu_result,
  output logic [N_BITS-1:0] alu_a,
  output logic [N_BITS-1:0] alu_b,
  output logic [5:0]        alu_op,
  output logic              tx_start,
  output logic [N_BITS-1:0] tx_data,
  output logic              busy,
  output logic              op_err,
  output logic              timeout
);

  state_t state;
  state_t state_next;
  logic   collecting;
  logic   accept;
  logic   abort;

  assign collecting = (state == ST_WAIT_A) || (state == ST_WAIT_B) ||
                      (state == ST_WAIT_OP);
  assign accept     = rx_done && collecting;

`ifdef UART_CTRL_TIMEOUT_EN
  logic count_en;
  logic expire;

  assign count_en = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

  ctrl_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept || !count_en),
    .count_en (count_en),
    .expire   (expire)
  );

  // A byte arriving on the expiry edge wins over the abort.
  assign abort = expire && !rx_done;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign abort = 1'b0;
`endif

  assign timeout = abort;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_WAIT_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_next unassigned
    // and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_WAIT_A:  if (rx_done) state_next = ST_WAIT_B;
      ST_WAIT_B:  if (rx_done) state_next = ST_WAIT_OP;
                  else if (abort) state_next = ST_WAIT_A;
      ST_WAIT_OP: if (rx_done) state_next = ST_CALC;
                  else if (abort) state_next = ST_WAIT_A;
      ST_CALC:    state_next = ST_SEND;
      ST_SEND:    state_next = ST_WAIT_TX;
      // rx_done here is ignored even when it coincides with tx_done.
      ST_WAIT_TX: if (tx_done) state_next = ST_WAIT_A;
      default:    state_next = ST_WAIT_A;
    endcase
  end

  // Output decode; all outputs here depend only on registered state/opcode.
  always_comb begin
    tx_start = 1'b0;
    busy     = 1'b0;
    op_err   = 1'b0;
    unique case (state)
      ST_CALC: begin
        busy   = 1'b1;
        op_err = !op_supported(alu_op);
      end
      ST_SEND: begin
        busy     = 1'b1;
        tx_start = 1'b1;
      end
      ST_WAIT_TX: busy = 1'b1;
      default: ;
    endcase
  end

  // Operand, opcode and result registers. Operands persist after the frame
  // and are only overwritten by the next accepted byte (or an abort).
  always_ff @(posedge clock) begin
    if (!reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      tx_data <= '0;
    end else begin
      if (abort) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= '0;
      end else if (accept) begin
        unique case (state)
          ST_WAIT_A:  alu_a  <= rx_data;
          ST_WAIT_B:  alu_b  <= rx_data;
          ST_WAIT_OP: alu_op <= rx_data[5:0];
          default: ;
        endcase
      end

      if (state == ST_CALC) begin
        tx_data <= op_supported(alu_op) ? alu_result : ERR_CODE;
      end
    end
  end

endmodule
